// File: rtl/pixel_plot_pkg.sv
// Shared constants and types for the pixel plot sink: screen geometry, pixel record, FSM states.
package pixel_plot_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOUR_W = 3;
    localparam int FB_LAST  = SCREEN_W * SCREEN_H - 1;

    typedef struct packed {
        logic [7:0]          x;
        logic [6:0]          y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } plot_state_t;

    // y*160 + x as shifts, so the row multiply never needs a multiplier.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 7) + (yw << 5) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/pixel_plot_if.sv
// Valid/ready pixel plot channel between a drawing block (master) and the plot sink (slave).
interface pixel_plot_if;
    import pixel_plot_pkg::*;

    logic                plot_valid;
    logic                plot_ready;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;

    modport master (output plot_valid, output x, output y, output colour, input plot_ready);
    modport slave  (input plot_valid, input x, input y, input colour, output plot_ready);

endinterface

// File: rtl/plot_fifo.sv
// Small synchronous FIFO of pixel records; read data is the current head, valid while not empty.
module plot_fifo
    import pixel_plot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_push,
    input  pixel_t i_wdata,
    input  logic   i_pop,
    output pixel_t o_rdata,
    output logic   o_full,
    output logic   o_empty
);

    localparam int PW = $clog2(DEPTH);

    pixel_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Pixel plot sink: buffers plot requests and writes them to the 160x120 framebuffer, plus full-screen clear.
// Optional macro PLOT_BOUNDS_CHECK_EN: discard off-screen pixels and count them in dropped_cnt.
module pixel_plot_sink
    import pixel_plot_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    pixel_plot_if.slave         plot,
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
    output logic                busy,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic                fb_we,
    output logic [7:0]          dropped_cnt
);

    plot_state_t         r_state;
    plot_state_t         w_next_state;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_clr_wr;
    logic                w_clr_last;
    logic                w_in_range;
    pixel_t              w_wdata;
    pixel_t              w_head;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [COLOUR_W-1:0] r_clr_colour;

    assign w_wdata = '{x: plot.x, y: plot.y, colour: plot.colour};

    plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    assign w_clr_last = (r_clr_addr == ADDR_W'(FB_LAST));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (clear_req)    w_next_state = DRAIN;
            DRAIN:   if (w_fifo_empty) w_next_state = CLEAR;
            CLEAR:   if (w_clr_last)   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Pixels already queued are written before the clear sweep; the sweep itself stalls the FIFO.
    always_comb begin
        plot.plot_ready = !w_fifo_full && (r_state == IDLE);
        w_push          = plot.plot_valid && plot.plot_ready;
        w_pop           = !w_fifo_empty && (r_state != CLEAR);
        w_clr_wr        = (r_state == CLEAR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clr_addr   <= '0;
            r_clr_colour <= '0;
        end else begin
            if (r_state == IDLE && clear_req) r_clr_colour <= clear_colour;
            if (w_clr_wr) r_clr_addr <= r_clr_addr + ADDR_W'(1);
            else          r_clr_addr <= '0;
        end
    end

`ifdef PLOT_BOUNDS_CHECK_EN
    assign w_in_range = (w_head.x < 8'(SCREEN_W)) && (w_head.y < 7'(SCREEN_H));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dropped_cnt <= '0;
        else if (w_pop && !w_in_range && dropped_cnt != 8'hFF) dropped_cnt <= dropped_cnt + 8'd1;
    end
`else
    // Off-screen pixels wrap through the truncated address instead of being filtered.
    assign w_in_range  = 1'b1;
    assign dropped_cnt = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else if (w_clr_wr) begin
            fb_we   <= 1'b1;
            fb_addr <= r_clr_addr;
            fb_data <= r_clr_colour;
        end else if (w_pop && w_in_range) begin
            fb_we   <= 1'b1;
            fb_addr <= pixel_addr(w_head.x, w_head.y);
            fb_data <= w_head.colour;
        end else begin
            fb_we   <= 1'b0;
        end
    end

    assign busy = (r_state != IDLE) || !w_fifo_empty || fb_we;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: expected framebuffer writes queued at stimulus, popped by a monitor.
module tb_pixel_plot_sink;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_colour = '0;
    logic       busy;
    logic [14:0] fb_addr;
    logic [2:0] fb_data;
    logic       fb_we;
    logic [7:0] dropped_cnt;

    pixel_plot_if p_if ();

    pixel_plot_sink dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .plot         (p_if),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .busy         (busy),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .dropped_cnt  (dropped_cnt)
    );

    always #5 clk = ~clk;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  m_drops  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: a pixel lands at row*160+column within a 32768-word space, or is dropped when filtering.
    task automatic model_pixel(input int x, input int y, input int c);
        wr_t w;
`ifdef PLOT_BOUNDS_CHECK_EN
        if (x >= 160 || y >= 120) begin
            if (m_drops < 255) m_drops++;
            return;
        end
`endif
        w.addr = (y * 160 + x) % 32768;
        w.data = c;
        sb.push_back(w);
    endtask

    task automatic model_clear(input int c);
        wr_t w;
        for (int a = 0; a < 160 * 120; a++) begin
            w.addr = a;
            w.data = c;
            sb.push_back(w);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && fb_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", int'(fb_addr), -1);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", int'(fb_addr), e.addr);
                chk("wr_data", int'(fb_data), e.data);
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 right after the transfer edge.
    task automatic send(input int x, input int y, input int c, output int stalled);
        int t;
        t = 0;
        p_if.x = 8'(x);
        p_if.y = 7'(y);
        p_if.colour = 3'(c);
        p_if.plot_valid = 1'b1;
        @(negedge clk);
        while (!p_if.plot_ready && t < 30000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30000) chk("send_timeout", t, 0);
        stalled = (t > 0) ? 1 : 0;
        @(posedge clk);
        model_pixel(x, y, c);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < 25000) begin
            @(negedge clk);
            t++;
        end
        chk(name, int'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        int stalls;
        int ready_ones;
        int t;
        p_if.plot_valid = 1'b0;
        p_if.x = '0;
        p_if.y = '0;
        p_if.colour = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_dropped", int'(dropped_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(p_if.plot_ready), 1);
        @(posedge clk);
        #1;

        // single pixel and its latency
        send(10, 5, 5, s);
        p_if.plot_valid = 1'b0;
        @(negedge clk);
        chk("t1_we_early", int'(fb_we), 0);
        @(negedge clk);
        chk("t1_we", int'(fb_we), 1);
        chk("t1_addr", int'(fb_addr), 810);
        chk("t1_data", int'(fb_data), 5);
        @(negedge clk);
        chk("t1_single_pulse", int'(fb_we), 0);
        wait_idle("t1_idle");

        // X symbol stream with valid held
        stalls = 0;
        for (int i = 0; i < 17; i++) begin
            send(20 + i, 30 + i, i % 8, s);
            stalls += s;
        end
        for (int i = 0; i < 17; i++) begin
            if (i != 8) begin
                send(36 - i, 30 + i, (i + 3) % 8, s);
                stalls += s;
            end
        end
        p_if.plot_valid = 1'b0;
        chk("t2_no_stall", stalls, 0);
        wait_idle("t2_idle");

        // corner and off-screen pixels
        send(159, 119, 7, s);
        send(160, 0, 1, s);
        p_if.plot_valid = 1'b0;
        wait_idle("t4_idle");
        chk("t4_dropped", int'(dropped_cnt), m_drops);

        // randomized stream with gaps and occasional off-screen coordinates
        for (int i = 0; i < 300; i++) begin
            int gap;
            int x;
            int y;
            gap = $urandom_range(0, 3);
            if (gap != 0) begin
                p_if.plot_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 159);
            y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 119);
            send(x, y, $urandom_range(0, 7), s);
        end
        p_if.plot_valid = 1'b0;
        wait_idle("rand_idle");
`ifdef PLOT_BOUNDS_CHECK_EN
        chk("rand_dropped", int'(dropped_cnt), m_drops);
`else
        chk("rand_dropped", int'(dropped_cnt), 0);
`endif

        // clear with pixels queued ahead of it; a second clear_req mid-sweep is ignored
        send(1, 1, 1, s);
        send(2, 2, 2, s);
        p_if.x = 8'd3;
        p_if.y = 7'd3;
        p_if.colour = 3'd3;
        clear_req = 1'b1;
        clear_colour = 3'b010;
        @(negedge clk);
        chk("t3_ready_before", int'(p_if.plot_ready), 1);
        @(posedge clk);
        model_pixel(3, 3, 3);
        model_clear(2);
        #1;
        clear_req = 1'b0;
        p_if.plot_valid = 1'b0;
        ready_ones = 0;
        for (int i = 0; i < 19200; i++) begin
            @(negedge clk);
            if (p_if.plot_ready) ready_ones++;
            if (i == 100) begin
                clear_req = 1'b1;
                clear_colour = 3'b101;
            end else begin
                clear_req = 1'b0;
            end
        end
        chk("t3_ready_low", ready_ones, 0);
        wait_idle("t3_idle");
        chk("t3_drained", sb.size(), 0);

        // reset in the middle of a clear sweep
        clear_req = 1'b1;
        clear_colour = 3'b110;
        @(posedge clk);
        model_clear(6);
        #1;
        clear_req = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(fb_we && fb_addr == 15'd500) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("t5_reach_500", int'(fb_addr), 500);
        #1;
        reset_n = 1'b0;
        m_drops = 0;
        #1;
        chk("t5_we_abort", int'(fb_we), 0);
        chk("t5_busy_abort", int'(busy), 0);
        chk("t5_dropped_rst", int'(dropped_cnt), 0);
        sb.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", int'(p_if.plot_ready), 1);
        chk("t5_busy_after", int'(busy), 0);
        @(posedge clk);
        #1;
        send(5, 6, 4, s);
        p_if.plot_valid = 1'b0;
        wait_idle("t5_idle");

        chk("final_sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
